// File: rtl/exe_muldiv.sv
// Multi-cycle RV32M multiply/divide unit.
// Multiplication uses unsigned shift-add, one step per cycle. Division uses
// restoring shift-subtract, one quotient bit per cycle. Signs are stripped on
// entry and re-applied on the final step. Divide-by-zero and signed overflow
// bypass the iteration and finish in the cycle after acceptance.
module exe_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      reg_wr_addr_i,
   input  logic            flush_i,
   output logic            hold_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic            reg_wr_en_o,
   output logic [4:0]      reg_wr_addr_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   state_t             state_reg, state_next;
   logic [2:0]         funct3_reg;
   logic [4:0]         addr_reg;
   logic [XLEN-1:0]    mag1_reg;     // multiplicand, or dividend shifting out MSB-first
   logic [XLEN-1:0]    mag2_reg;     // multiplier shifting out LSB-first, or divisor
   logic [XLEN-1:0]    result_reg;
   logic               sign_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2*XLEN-1:0]  acc_reg;      // product, or {partial remainder, quotient}

   // ---------------- request decode ----------------
   logic            is_div_in, s1_en, s2_en, s1, s2, sign_in;
   logic            div_zero, overflow, special, accept;
   logic [XLEN-1:0] abs1, abs2, special_result;

   assign is_div_in = funct3_i[2];
   // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
   assign s1_en = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                  (funct3_i == 3'b100) | (funct3_i == 3'b110);
   assign s2_en = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
   assign s1 = s1_en & op1_i[XLEN-1];
   assign s2 = s2_en & op2_i[XLEN-1];
   assign abs1 = s1 ? (~op1_i + 1'b1) : op1_i;
   assign abs2 = s2 ? (~op2_i + 1'b1) : op2_i;
   // Remainder takes the dividend's sign; everything else is s1^s2.
   assign sign_in = (is_div_in & funct3_i[1]) ? s1 : (s1 ^ s2);

   assign div_zero = is_div_in & (op2_i == '0);
   assign overflow = is_div_in & ~funct3_i[0] & (op1_i == MIN_NEG) & (op2_i == ALL_ONES);
   assign special  = div_zero | overflow;
   // Remainder ops: dividend on /0, zero on overflow. Quotient ops: all ones on /0, dividend on overflow.
   assign special_result = funct3_i[1] ? (div_zero ? op1_i : '0)
                                       : (div_zero ? ALL_ONES : op1_i);

   assign accept = (state_reg == IDLE) & start_i & ~flush_i;

   // ---------------- iteration step ----------------
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic              div_q, last_step;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, prod_fix;
   logic [XLEN-1:0]   quot_raw, rem_raw, quot_fix, rem_fix, final_result;

   assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (mag2_reg[0] ? {1'b0, mag1_reg} : '0);
   assign mul_acc   = {mul_sum, acc_reg[XLEN-1:1]};
   assign div_shift = {acc_reg[2*XLEN-1:XLEN], mag1_reg[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, mag2_reg};
   assign div_q     = ~div_diff[XLEN];
   assign div_rem   = div_q ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
   assign div_acc   = {div_rem, acc_reg[XLEN-2:0], div_q};
   assign step_acc  = funct3_reg[2] ? div_acc : mul_acc;
   assign last_step = (cnt_reg == LAST_CNT);

   assign quot_raw = step_acc[XLEN-1:0];
   assign rem_raw  = step_acc[2*XLEN-1:XLEN];
   assign prod_fix = (sign_reg && step_acc != '0) ? (~step_acc + 1'b1) : step_acc;
   assign quot_fix = (sign_reg && quot_raw != '0) ? (~quot_raw + 1'b1) : quot_raw;
   assign rem_fix  = (sign_reg && rem_raw  != '0) ? (~rem_raw  + 1'b1) : rem_raw;

   // Pick the signed-corrected result for the latched operation.
   always_comb begin
      final_result = '0;
      case (funct3_reg)
         3'b000:                final_result = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_result = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:        final_result = quot_fix;
         default:               final_result = rem_fix;
      endcase
   end

   // ---------------- control FSM ----------------
   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: flush always returns to IDLE; specials skip CALC.
   always_comb begin
      state_next = state_reg;
      if (flush_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (start_i) state_next = special ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Operand capture on accept, one arithmetic step per CALC cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         funct3_reg <= '0;
         addr_reg   <= '0;
         mag1_reg   <= '0;
         mag2_reg   <= '0;
         result_reg <= '0;
         sign_reg   <= 1'b0;
         cnt_reg    <= '0;
         acc_reg    <= '0;
      end else if (flush_i) begin
         cnt_reg <= '0;
         acc_reg <= '0;
      end else if (accept) begin
         funct3_reg <= funct3_i;
         addr_reg   <= reg_wr_addr_i;
         mag1_reg   <= abs1;
         mag2_reg   <= abs2;
         sign_reg   <= sign_in;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         if (special) result_reg <= special_result;
      end else if (state_reg == CALC) begin
         acc_reg <= step_acc;
         cnt_reg <= cnt_reg + 1'b1;
         if (funct3_reg[2]) mag1_reg <= {mag1_reg[XLEN-2:0], 1'b0};
         else               mag2_reg <= {1'b0, mag2_reg[XLEN-1:1]};
         if (last_step) result_reg <= final_result;
      end
   end

   // ---------------- outputs ----------------
   assign hold_o        = accept | (state_reg == CALC);
   assign valid_o       = (state_reg == DONE) & ~flush_i;
   assign reg_wr_en_o   = valid_o;
   assign result_o      = valid_o ? result_reg : '0;
   assign reg_wr_addr_o = valid_o ? addr_reg : '0;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv at XLEN=32 plus one XLEN=8 instance.
module tb_exe_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic        sel = 1'b0;        // 0: drive XLEN=32 unit, 1: drive XLEN=8 unit
   logic [2:0]  f3 = '0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [4:0]  waddr = '0;

   logic        hold32, valid32, wen32, hold8, valid8, wen8;
   logic [31:0] res32;
   logic [7:0]  res8;
   logic [4:0]  addr32, addr8;
   logic        start32, start8;

   logic        hold, valid, wen;
   logic [31:0] res;
   logic [4:0]  raddr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign start32 = start & ~sel;
   assign start8  = start & sel;
   assign hold    = sel ? hold8  : hold32;
   assign valid   = sel ? valid8 : valid32;
   assign wen     = sel ? wen8   : wen32;
   assign res     = sel ? {24'd0, res8} : res32;
   assign raddr   = sel ? addr8  : addr32;

   exe_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start_i(start32), .funct3_i(f3),
      .op1_i(op1), .op2_i(op2), .reg_wr_addr_i(waddr), .flush_i(flush),
      .hold_o(hold32), .valid_o(valid32), .result_o(res32),
      .reg_wr_en_o(wen32), .reg_wr_addr_o(addr32)
   );

   exe_muldiv #(.XLEN(8)) dut8 (
      .clk(clk), .rst(rst), .start_i(start8), .funct3_i(f3),
      .op1_i(op1[7:0]), .op2_i(op2[7:0]), .reg_wr_addr_i(waddr), .flush_i(flush),
      .hold_o(hold8), .valid_o(valid8), .result_o(res8),
      .reg_wr_en_o(wen8), .reg_wr_addr_o(addr8)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_hold"},   hold,  0);
      check_eq({tag, "_valid"},  valid, 0);
      check_eq({tag, "_wen"},    wen,   0);
      check_eq({tag, "_result"}, res,   0);
      check_eq({tag, "_addr"},   raddr, 0);
   endtask

   // Issue one op in cycle 0, scramble operands afterwards, and expect valid
   // in cycle exp_cyc with hold high in exactly cycles 0..exp_cyc-1.
   task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_cyc);
      int cyc = 0;
      int hold_cnt = 0;
      bit seen = 0;
      @(posedge clk); #1;
      start = 1'b1; f3 = fn; op1 = a; op2 = b; waddr = rd;
      while (cyc <= 40) begin
         @(negedge clk);
         if (hold) hold_cnt++;
         if (valid) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
         start = 1'b0; op1 = $urandom; op2 = $urandom; waddr = 5'($urandom);
         cyc++;
      end
      check_eq({tag, "_seen"}, seen, 1);
      check_eq({tag, "_cycle"}, cyc, exp_cyc);
      check_eq({tag, "_hold_cycles"}, hold_cnt, exp_cyc);
      check_eq({tag, "_result"}, res, exp_res);
      check_eq({tag, "_addr"}, raddr, rd);
      check_eq({tag, "_wen"}, wen, 1);
      $display("op %s: f3=%0d a=%h b=%h -> result=%h cycle=%0d addr=%0d",
               tag, fn, a, b, res, cyc, raddr);
      @(posedge clk); #1;
      start = 1'b0; op1 = '0; op2 = '0; waddr = '0;
   endtask

   int vcount;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Multiply family
      run_op("mul_7x-3",   3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
      run_op("mulh",       3'b001, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h00000000, 33);
      run_op("mulhsu",     3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd3, 32'h80000000, 33);
      run_op("mulhu",      3'b011, 32'h80000000, 32'hFFFFFFFF, 5'd4, 32'h7FFFFFFF, 33);
      run_op("mulh_neg",   3'b001, 32'hFFFFFFFF, 32'd5,        5'd5, 32'hFFFFFFFF, 33);

      // Divide family
      run_op("div_-7/2",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFD, 33);
      run_op("rem_-7/2",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd7, 32'hFFFFFFFF, 33);
      run_op("divu_big",   3'b101, 32'hFFFFFFFE, 32'd3,        5'd8, 32'h55555554, 33);
      run_op("rem_7/-2",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd9, 32'h00000001, 33);
      run_op("remu_17/5",  3'b111, 32'd17,       32'd5,        5'd10, 32'd2,       33);
      run_op("div_0/-5",   3'b100, 32'd0,        32'hFFFFFFFB, 5'd11, 32'd0,       33);

      // Special cases finish in cycle 1
      run_op("divu_5/0",   3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
      run_op("rem_5/0",    3'b110, 32'd5,        32'd0,        5'd13, 32'd5,        1);
      run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
      run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1);

      // Flush in cycle 10 of a DIV, then MUL 3x4 starting cycle 12
      vcount = 0;
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'b100; op1 = 32'd1000; op2 = 32'd7; waddr = 5'd20;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (valid) vcount++;
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 10) flush = 1'b1;
      end
      @(negedge clk);
      if (valid) vcount++;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_eq("flush_hold_c11", hold, 0);
      check_eq("flush_valid_c11", valid, 0);
      check_eq("flush_no_valid", vcount, 0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33);

      // Flush together with start in IDLE: not accepted
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; f3 = 3'b000; op1 = 32'd2; op2 = 32'd2; waddr = 5'd22;
      @(negedge clk);
      check_eq("flush_start_hold", hold, 0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      vcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (valid || hold) vcount++;
         @(posedge clk); #1;
      end
      check_eq("flush_start_ignored", vcount, 0);
      $display("op flush_with_start: activity=%0d", vcount);

      // Reset in cycle 5 of a MUL while start toggles
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'b000; op1 = 32'd9; op2 = 32'd9; waddr = 5'd23;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         start = c[0];
         if (c == 5) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_mid_calc");
      vcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (valid) vcount++;
      end
      check_eq("rst_no_stale_valid", vcount, 0);
      $display("op reset_mid_calc: stale_valids=%0d", vcount);

      // XLEN=8 instance
      sel = 1'b1;
      run_op("x8_mulhu", 3'b011, 32'hFF, 32'hFF, 5'd24, 32'hFE, 9);
      run_op("x8_div",   3'b100, 32'hF9, 32'h02, 5'd25, 32'hFD, 9);
      sel = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Multi-cycle RV32M multiply/divide unit, parametrised in operand width, that sits beside the single-cycle execution stage. Decode issues MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU here. The unit holds the pipeline through `hold_o` while it iterates. It returns one result with write-back address and enable, and an interrupt or flush cancels it cleanly.

## Interface
- `XLEN`, 32: operand/result width; power of two, >= 8.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width; derived, not overridden.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start_i`  in  1  request; sampled only in IDLE.
- `funct3_i`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1_i`  in  XLEN  rs1 value (multiplicand / dividend).
- `op2_i`  in  XLEN  rs2 value (multiplier / divisor).
- `reg_wr_addr_i`  in  5  destination register.
- `flush_i`  in  1  abort (interrupt or jump); highest priority after `rst`.
- `hold_o`  out  1  pipeline stall request; combinational.
- `valid_o`  out  1  result valid, one-cycle pulse.
- `result_o`  out  XLEN  result; 0 when `valid_o`=0.
- `reg_wr_en_o`  out  1  equals `valid_o`.
- `reg_wr_addr_o`  out  5  latched destination; 0 when `valid_o`=0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `start_i`=1, `flush_i`=0:
  - Latch funct3 and destination.
  - Latch operand magnitudes. Signed operand = two's-complement absolute value: op1 for MULH/MULHSU/DIV/REM, op2 for MULH/DIV/REM.
  - Latch the result sign: product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1.
  - Clear the counter and the 2*XLEN accumulator.
  - Go to CALC, except for the special cases below, which go straight to DONE with a preloaded result.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = op1_i unchanged (both signed and unsigned).
  - Signed overflow (op1 = 1<<(XLEN-1), op2 = all ones, DIV/REM): quotient = op1_i, remainder = 0.
- CALC, multiply: one shift-add step per cycle on an unsigned XLEN x XLEN -> 2*XLEN product.
- CALC, divide: one restoring shift-subtract step per cycle, producing one quotient bit per cycle; the partial remainder is XLEN+1 bits.
- The counter increments each CALC cycle. When it reaches XLEN-1, the final step completes and the state goes to DONE.
- Sign fix: negate the raw product, quotient or remainder iff its latched sign=1 and the value is nonzero. Apply the fix when entering DONE.
- Result select: MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2XLEN-1:XLEN]; DIV/DIVU take the quotient; REM/REMU take the remainder.
- DONE: `valid_o`=1, `reg_wr_en_o`=1, result and address driven. Next state is IDLE unconditionally.
- `start_i` in CALC or DONE is ignored; a new request is accepted no earlier than the IDLE cycle after DONE.
- `flush_i`=1 in any state: next state is IDLE, no `valid_o`, accumulator contents discarded. `flush_i` together with `start_i` in IDLE means the start is not accepted.
- `rst`: state IDLE, counter and all registers 0, every output 0.

## Timing
- `hold_o` = (IDLE & `start_i` & ~`flush_i`) | CALC. It is 0 in DONE so the pipeline advances while write-back happens.
- Normal latency: start in cycle 0, CALC in cycles 1..XLEN, DONE/`valid_o` in cycle XLEN+1. That is XLEN+1 cycles, 33 at XLEN=32.
- Special-case latency: `valid_o` in cycle 1, with `hold_o` high only in cycle 0.
- Operands are sampled only at the accepting edge; later changes on `op1_i`/`op2_i` have no effect.
- Back-to-back: earliest second start is cycle XLEN+2.
- Reset mid-CALC: outputs 0 in the cycle after the reset edge, and no stale `valid_o` afterwards.

## Test plan
- MUL 7 x -3 (op2=0xFFFFFFFD) -> `valid_o` in cycle 33, result 0xFFFFFFEB, `hold_o` high cycles 0..32.
- MULH, MULHSU and MULHU with op1=0x80000000, op2=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/3 -> 0x55555554.
- Divide by zero, DIVU 5/0 -> result 0xFFFFFFFF and REM 5/0 -> 5, each in cycle 1. Overflow case DIV 0x80000000/-1 -> 0x80000000 in cycle 1.
- `flush_i` pulsed in cycle 10 of a DIV -> IDLE in cycle 11, no `valid_o`, `hold_o` 0. A new MUL 3x4 started in cycle 12 -> 12 in cycle 45, with `reg_wr_addr_o` equal to the new destination.
- `rst` asserted in cycle 5 of a MUL while `start_i` toggles in CALC -> all outputs 0 from cycle 6 and no spurious `valid_o`. At XLEN=8, MULHU 0xFF x 0xFF -> 0xFE in cycle 9.
